pipe_request_demux: RTL



---
 rtl/pipe_demux_pkg.sv | 17 +
 rtl/pipe_request_demux_if.sv | 26 ++
 rtl/pipe_demux_fifo.sv | 55 +++++
 rtl/pipe_request_demux.sv | 94 +++++++++
 4 files changed

// File: rtl/pipe_demux_pkg.sv
// Shared tag constants, tag check helper and the default-width pipe word layout.
package pipe_demux_pkg;

    localparam int TAG_NONE       = 0;
    localparam int DEF_TAG_WIDTH  = 8;
    localparam int DEF_DATA_WIDTH = 64;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] payload;
    } pipe_word_def_t;

    function automatic logic tag_valid(input logic [31:0] tag, input int num_methods);
        return (tag != 32'(TAG_NONE)) && (tag <= 32'(num_methods));
    endfunction

endpackage

// File: rtl/pipe_request_demux_if.sv
// Pipe enq side, method call side and status of the request demux.
interface pipe_request_demux_if #(
    parameter int NUM_METHODS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 8,
    parameter int DEPTH       = 4
);
    logic                          pipe_enq_ENA;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] pipe_enq_v;
    logic                          pipe_enq_RDY;
    logic [NUM_METHODS-1:0]        meth_ENA;
    logic [DATA_WIDTH-1:0]         meth_v;
    logic [NUM_METHODS-1:0]        meth_RDY;
    logic [$clog2(DEPTH):0]        occupancy;
    logic [15:0]                   bad_tag_count;

    modport master (
        output pipe_enq_ENA, pipe_enq_v, meth_RDY,
        input  pipe_enq_RDY, meth_ENA, meth_v, occupancy, bad_tag_count
    );

    modport slave (
        input  pipe_enq_ENA, pipe_enq_v, meth_RDY,
        output pipe_enq_RDY, meth_ENA, meth_v, occupancy, bad_tag_count
    );
endinterface

// File: rtl/pipe_demux_fifo.sv
// In-order DEPTH-entry FIFO with wrap-bit pointers; read data is the head entry.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full and pop while empty are ignored.
module pipe_demux_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdat_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (nRST && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
    end

endmodule

// File: rtl/pipe_request_demux.sv
// Demuxes tagged pipe words to one-hot method calls in order; bad tags are dropped and counted.
// Latency: 1 cycle accept-to-call (0 when PIPE_DEMUX_BYPASS_EN is defined and the FIFO is empty).
// Backpressure: pipe_enq_RDY = !full only; a non-ready head method stalls all later words.
module pipe_request_demux
    import pipe_demux_pkg::*;
#(
    parameter int NUM_METHODS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 8,
    parameter int DEPTH       = 4
) (
    input  logic               CLK,
    input  logic               nRST,
    pipe_request_demux_if.slave bus
);
    localparam int W = TAG_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] payload;
    } pipe_word_t;

    pipe_word_t             in_word, head_word;
    logic [W-1:0]           head_raw;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   accept, in_valid, head_valid;
    logic                   push, pop;
    logic [NUM_METHODS-1:0] meth_ena;
    logic [DATA_WIDTH-1:0]  meth_dat;
    logic [15:0]            bad_cnt_q, bad_cnt_d;

    assign in_word   = bus.pipe_enq_v;
    assign head_word = head_raw;

    assign bus.pipe_enq_RDY = nRST && !fifo_full;
    assign accept           = bus.pipe_enq_ENA && bus.pipe_enq_RDY;
    assign in_valid         = tag_valid(32'(in_word.tag), NUM_METHODS);
    assign head_valid       = nRST && !fifo_empty;

    // Only valid tags are ever written, so the head tag always selects a real method.
    always_comb begin
        meth_ena = '0;
        meth_dat = head_word.payload;
        push     = accept && in_valid;
        pop      = 1'b0;
        for (int i = 0; i < NUM_METHODS; i++) begin
            if (head_valid && (32'(head_word.tag) == 32'(i + 1))) begin
                meth_ena[i] = bus.meth_RDY[i];
                pop         = bus.meth_RDY[i];
            end
        end
`ifdef PIPE_DEMUX_BYPASS_EN
        for (int i = 0; i < NUM_METHODS; i++) begin
            if (nRST && fifo_empty && push && (32'(in_word.tag) == 32'(i + 1)) && bus.meth_RDY[i]) begin
                meth_ena[i] = 1'b1;
                meth_dat    = in_word.payload;
                push        = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        bad_cnt_d = bad_cnt_q;
        if (accept && !in_valid && (bad_cnt_q != 16'hFFFF)) bad_cnt_d = bad_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) bad_cnt_q <= '0;
        else       bad_cnt_q <= bad_cnt_d;
    end

    pipe_demux_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .push_i  (push),
        .wdat_i  (in_word),
        .pop_i   (pop),
        .rdat_o  (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.meth_ENA      = meth_ena;
    assign bus.meth_v        = meth_dat;
    assign bus.occupancy     = fifo_count;
    assign bus.bad_tag_count = bad_cnt_q;

endmodule
